// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the framed byte-stream Icache boot loader.
package boot_loader_pkg;

    localparam logic [7:0]  SYNC_BYTE_DEF  = 8'hA5;
    localparam int unsigned FRAME_OVERHEAD = 3;      // SYNC + LEN + CHK bytes around the payload
    localparam int unsigned WORD_BYTES     = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } boot_state_e;

endpackage

// File: rtl/boot_loader_if.sv
// Byte-source handshake plus Icache boot port, grouped for the loader boundary.
interface boot_loader_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  boot_up;
    logic [ADDR_WIDTH-1:0] boot_addr;
    logic [31:0]           boot_datai;
    logic                  boot_done;
    logic                  boot_err;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, boot_up, boot_addr, boot_datai, boot_done, boot_err
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, boot_up, boot_addr, boot_datai, boot_done, boot_err
    );
endinterface

// File: rtl/boot_word_asm.sv
// Little-endian word assembler: collects four bytes and flags the completing one.
module boot_word_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_c,
    output logic [31:0] word_c
);

    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] shift_q, shift_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q <= 2'd0;
            shift_q    <= 32'd0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

    // The completing word includes the current byte so the top can latch it on this edge.
    always_comb begin
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        word_valid_c = 1'b0;
        word_c       = shift_q;
        if (clear_i) begin
            byte_cnt_d = 2'd0;
        end else if (byte_valid_i) begin
            shift_d[8*byte_cnt_q +: 8] = byte_i;
            byte_cnt_d                 = byte_cnt_q + 2'd1;
            word_valid_c               = (byte_cnt_q == 2'd3);
            word_c                     = {byte_i, shift_q[23:0]};
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Frame parser that loads (LEN+1) words into the Icache and releases the core on a good checksum.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned ADDR_NUM   = 256,
    parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEF
) (
    input  logic         clk,
    input  logic         rst,
    boot_loader_if.slave bus
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    boot_state_e           state_q, state_d;
    logic                  rx_ready_q;
    logic                  boot_up_q, boot_up_d;
    logic [ADDR_WIDTH-1:0] boot_addr_q, boot_addr_d;
    logic [31:0]           boot_datai_q, boot_datai_d;
    logic                  boot_done_q, boot_done_d;
    logic                  boot_err_q, boot_err_d;
    logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            chk_q, chk_d;

    logic        fire;
    logic [7:0]  rx_byte;
    logic        asm_clear, asm_valid, word_valid_c;
    logic [31:0] word_c;

    assign fire    = bus.rx_valid && rx_ready_q;
    assign rx_byte = bus.rx_data;

    boot_word_asm u_word_asm (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (asm_clear),
        .byte_valid_i (asm_valid),
        .byte_i       (rx_byte),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rx_ready_q   <= 1'b0;
            boot_up_q    <= 1'b1;
            boot_addr_q  <= '0;
            boot_datai_q <= 32'd0;
            boot_done_q  <= 1'b0;
            boot_err_q   <= 1'b0;
            word_cnt_q   <= '0;
            len_q        <= 8'd0;
            chk_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            rx_ready_q   <= 1'b1;
            boot_up_q    <= boot_up_d;
            boot_addr_q  <= boot_addr_d;
            boot_datai_q <= boot_datai_d;
            boot_done_q  <= boot_done_d;
            boot_err_q   <= boot_err_d;
            word_cnt_q   <= word_cnt_d;
            len_q        <= len_d;
            chk_q        <= chk_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        boot_up_d    = boot_up_q;
        boot_addr_d  = boot_addr_q;
        boot_datai_d = boot_datai_q;
        boot_done_d  = boot_done_q;
        boot_err_d   = boot_err_q;
        word_cnt_d   = word_cnt_q;
        len_d        = len_q;
        chk_d        = chk_q;
        asm_clear    = 1'b0;
        asm_valid    = 1'b0;

        unique case (state_q)
            // A sync byte (re)starts a frame from any idle-like state, holding the core.
            ST_IDLE, ST_ERR, ST_DONE: begin
                if (fire && (rx_byte == SYNC_BYTE)) begin
                    state_d     = ST_LEN;
                    boot_up_d   = 1'b1;
                    boot_done_d = 1'b0;
                    boot_err_d  = 1'b0;
                    chk_d       = 8'd0;
                    boot_addr_d = '0;
                    word_cnt_d  = '0;
                end
            end
            ST_LEN: begin
                if (fire) begin
                    len_d = rx_byte;
                    chk_d = rx_byte;
                    if ((32'(rx_byte) + 32'd1) > ADDR_NUM) begin
                        state_d    = ST_ERR;
                        boot_err_d = 1'b1;
                    end else begin
                        state_d   = ST_DATA;
                        asm_clear = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (fire) begin
                    asm_valid = 1'b1;
                    chk_d     = chk_q ^ rx_byte;
                    if (word_valid_c) begin
                        boot_datai_d = word_c;
                        boot_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
                        word_cnt_d   = word_cnt_q + CNT_W'(1);
                        if (32'(word_cnt_q) == 32'(len_q)) begin
                            state_d = ST_CHK;
                        end
                    end
                end
            end
            ST_CHK: begin
                if (fire) begin
                    if (rx_byte == chk_q) begin
                        state_d     = ST_DONE;
                        boot_done_d = 1'b1;
                        boot_up_d   = 1'b0;
                    end else begin
                        state_d    = ST_ERR;
                        boot_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.boot_up    = boot_up_q;
    assign bus.boot_addr  = boot_addr_q;
    assign bus.boot_datai = boot_datai_q;
    assign bus.boot_done  = boot_done_q;
    assign bus.boot_err   = boot_err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: reset, good/bad frames, garbage, max length, gaps and reload.
module tb_boot_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    boot_loader_if #(.ADDR_WIDTH(8)) bus ();

    boot_loader #(
        .ADDR_WIDTH (8),
        .ADDR_NUM   (256),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one byte for exactly one transfer edge, optionally after idle gap cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b0;
        for (int k = 0; k < gap; k++) begin
            @(posedge clk);
            #1;
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_good_frame(input bit gaps);
        logic [7:0] fr [11];
        fr = '{8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h91};
        for (int i = 0; i < 11; i++) begin
            send_byte(fr[i], gaps ? int'($urandom_range(0, 3)) : 0);
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"}, 32'(bus.boot_done), 32'd1);
        check({tag, "_up"},   32'(bus.boot_up),   32'd0);
        check({tag, "_err"},  32'(bus.boot_err),  32'd0);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset values while held in reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.rx_ready),  32'd0);
        check("rst_up",    32'(bus.boot_up),   32'd1);
        check("rst_addr",  32'(bus.boot_addr), 32'd0);
        check("rst_data",  bus.boot_datai,     32'd0);
        check("rst_done",  32'(bus.boot_done), 32'd0);
        check("rst_err",   32'(bus.boot_err),  32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rel_ready", 32'(bus.rx_ready), 32'd1);

        // Garbage in IDLE changes nothing
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h13, 0);
        idle(1);
        check("garb_up",   32'(bus.boot_up),   32'd1);
        check("garb_addr", 32'(bus.boot_addr), 32'd0);
        check("garb_data", bus.boot_datai,     32'd0);
        check("garb_done", 32'(bus.boot_done), 32'd0);
        check("garb_err",  32'(bus.boot_err),  32'd0);

        // Good frame, stepped byte by byte
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("w0_pre_data", bus.boot_datai, 32'd0);
        send_byte(8'h00, 0);
        check("w0_addr", 32'(bus.boot_addr), 32'd0);
        check("w0_data", bus.boot_datai,     32'h0000_0013);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        check("w1_addr", 32'(bus.boot_addr), 32'd1);
        check("w1_data", bus.boot_datai,     32'h0010_0093);
        check("w1_done", 32'(bus.boot_done), 32'd0);
        check("w1_up",   32'(bus.boot_up),   32'd1);
        send_byte(8'h91, 0);
        check_done("good");
        idle(2);

        // Bad checksum, then a good frame recovers
        send_byte(8'hA5, 0);
        check("bad_sync_up",   32'(bus.boot_up),   32'd1);
        check("bad_sync_done", 32'(bus.boot_done), 32'd0);
        send_byte(8'h01, 0);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h93, 0); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
        send_byte(8'h90, 0);
        check("bad_err",  32'(bus.boot_err),  32'd1);
        check("bad_up",   32'(bus.boot_up),   32'd1);
        check("bad_done", 32'(bus.boot_done), 32'd0);
        send_byte(8'h13, 0);
        check("err_ignore", 32'(bus.boot_err), 32'd1);
        send_good_frame(1'b0);
        check_done("recover");

        // Reset mid-frame aborts immediately
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h13, 0);
        bus.rx_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(bus.rx_ready),  32'd0);
        check("mid_rst_up",    32'(bus.boot_up),   32'd1);
        check("mid_rst_addr",  32'(bus.boot_addr), 32'd0);
        check("mid_rst_data",  bus.boot_datai,     32'd0);
        check("mid_rst_done",  32'(bus.boot_done), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rel_ready", 32'(bus.rx_ready), 32'd1);

        // Maximum length: 256 words of value i; XOR of 0..255 is 0, so CHK = LEN = 0xFF
        send_byte(8'hA5, 0);
        send_byte(8'hFF, 0);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i), 0);
            send_byte(8'h00, 0);
            send_byte(8'h00, 0);
            send_byte(8'h00, 0);
            check($sformatf("max_addr%0d", i), 32'(bus.boot_addr), 32'(i));
            check($sformatf("max_data%0d", i), bus.boot_datai,     32'(i));
        end
        check("max_pre_done", 32'(bus.boot_done), 32'd0);
        send_byte(8'hFF, 0);
        check_done("max");
        idle(1);
        check("max_hold_addr", 32'(bus.boot_addr), 32'd255);

        // Sync value inside payload is data: four A5 bytes XOR to 0, CHK = 0x00
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 4; i++) send_byte(8'hA5, 0);
        check("sync_pl_data", bus.boot_datai, 32'hA5A5_A5A5);
        send_byte(8'h00, 0);
        check_done("sync_pl");

        // Random gaps give the same result as a back-to-back frame
        send_good_frame(1'b1);
        check("gap_addr", 32'(bus.boot_addr), 32'd1);
        check("gap_data", bus.boot_datai,     32'h0010_0093);
        check_done("gap");

        // Reload: CHK = 00^EF^BE^AD^DE = 0x22
        idle(1);
        send_byte(8'hA5, 1);
        check("reload_up",   32'(bus.boot_up),   32'd1);
        check("reload_done", 32'(bus.boot_done), 32'd0);
        send_byte(8'h00, int'($urandom_range(0, 3)));
        send_byte(8'hEF, int'($urandom_range(0, 3)));
        send_byte(8'hBE, int'($urandom_range(0, 3)));
        send_byte(8'hAD, int'($urandom_range(0, 3)));
        send_byte(8'hDE, int'($urandom_range(0, 3)));
        check("reload_addr", 32'(bus.boot_addr), 32'd0);
        check("reload_data", bus.boot_datai,     32'hDEAD_BEEF);
        send_byte(8'h22, int'($urandom_range(0, 3)));
        check_done("reload");
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Byte-stream program loader that sits directly upstream of the core's instruction-cache boot port.
- Receives a framed image from a byte source (UART receiver or test host) through a valid/ready handshake.
- Assembles little-endian 32-bit words and drives boot_up, boot_addr and boot_datai.
- Holds the core in boot until a frame passes its checksum, then releases it.

Parameters:
- ADDR_WIDTH, 8: Icache word-address width; must be ≤ 8.
- ADDR_NUM, 256: Icache depth in words; must equal 2^ADDR_WIDTH.
- SYNC_BYTE, 8'hA5: start-of-frame marker.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  byte available from the source.
- rx_data  in  8  byte value.
- rx_ready  out  1  loader accepts a byte; a transfer occurs when rx_valid && rx_ready on a rising clk edge.
- boot_up  out  1  holds the core in boot and write-enables the Icache.
- boot_addr  out  ADDR_WIDTH  Icache word address.
- boot_datai  out  32  Icache write data.
- boot_done  out  1  last frame loaded and verified.
- boot_err  out  1  last frame rejected.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, rx_ready=0, boot_up=1, boot_addr=0, boot_datai=0, boot_done=0, boot_err=0, byte_cnt=0, word_cnt=0, len=0, chk=0.
- rx_ready goes to 1 on the first clk edge after reset deasserts and stays 1 in every state. No back-pressure: every byte is consumed in one cycle.
- Frame format: SYNC_BYTE, LEN, then (LEN+1) words of 4 bytes each, LSB first, then CHK. CHK = XOR of LEN and every data byte.
- IDLE:
  - Accepted byte == SYNC_BYTE → LEN. On entry: boot_up=1, boot_done=0, boot_err=0, chk=0, boot_addr=0, word_cnt=0.
  - Any other byte is discarded; outputs unchanged.
- LEN:
  - Accepted byte L: len=L, chk=L.
  - If L+1 > ADDR_NUM → ERR.
  - Else → DATA with byte_cnt=0.
- DATA:
  - Each accepted byte goes into a shift register at position byte_cnt (byte 0 → bits 7:0) and is XORed into chk.
  - On the 4th byte, in the same edge: boot_datai ← assembled word, boot_addr ← word_cnt[ADDR_WIDTH-1:0], word_cnt++, byte_cnt=0.
  - boot_addr and boot_datai change atomically and are then held stable.
  - If word_cnt reaches len+1 → CHK.
- Icache writes: boot_up is level-high for the whole frame, so the Icache rewrites the held (addr,data) pair every cycle. This is harmless; the only ordering requirement is the atomic update above.
  - Before the first word completes, the pair (0,0) is written to address 0 and is overwritten by word 0.
- CHK:
  - Accepted byte == chk → DONE with boot_done=1, boot_up=0 (core released), one cycle after the CHK transfer.
  - Otherwise → ERR.
- ERR: boot_err=1 and boot_up stays 1 (core held). A SYNC_BYTE restarts the frame exactly as from IDLE; other bytes are ignored.
- DONE: a SYNC_BYTE re-enters LEN with boot_up=1, halting the core for reload. Other bytes are ignored.
- A SYNC_BYTE value appearing inside LEN, DATA or CHK is treated as payload; there is no resynchronisation mid-frame.
- Asserting rst at any point aborts the frame immediately and returns all outputs to their reset values. Partially written Icache contents are left as they are.
- word_cnt is ADDR_WIDTH+1 bits wide, so a LEN of 255 (256 words) has no wrap-around issue.

Decomposition:
- Shared package: state encoding (IDLE, LEN, DATA, CHK, DONE, ERR), the SYNC_BYTE default, and the frame-overhead constant.
- One natural sub-module, boot_word_asm: 2-bit byte counter plus 32-bit shift register. Outputs word_valid (pulse) and word. Has a clear input for frame restart.
- The FSM, address counter and checksum stay in boot_loader.

Test Plan:
- Reset: rst high mid-stream → all outputs at reset values (boot_up=1, rx_ready=0); rx_ready=1 one cycle after release.
- Good frame: bytes A5,01,13,00,00,00,93,00,10,00,91 → write (addr0, 0x00000013), then (addr1, 0x00100093); boot_done=1 and boot_up=0 one cycle after 0x91.
- Bad checksum: same frame with CHK=0x90 → boot_err=1, boot_up stays 1; then the good frame → boot_done=1, boot_err=0.
- Garbage then sync: 00,FF,13 in IDLE → no output change; then the good frame loads normally.
- Max length: LEN=0xFF, 256 words of value i → boot_addr runs 0..255 with boot_datai=i, no wrap; CHK = XOR of LEN and all data bytes → boot_done.
- Gaps and reload: rx_valid toggled randomly inside a frame → identical result; after DONE, a new A5 raises boot_up=1 and a second image overwrites the first.
